imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/mips_fetch_pkg.sv | 26 ++
 rtl/fetch_pc_gen.sv | 55 +++++
 rtl/imem_fetch_ctrl.sv | 179 +++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Holds the controller state encoding, default memory geometry and the
// word-aligned fetch legality helper used by the pc generator.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam int unsigned MEM_BYTES_DEF = 100;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP       = 32'd4;

    // A fetch address is usable only when it is word aligned and the whole
    // four-byte word lies inside memory. The sum is widened to 33 bits so an
    // address near 2^32 cannot wrap into a small, falsely legal value.
    function automatic logic pc_is_legal(input logic [31:0] pc,
                                         input int unsigned mem_bytes);
        logic [32:0] last_byte;
        last_byte = {1'b0, pc} + 33'd3;
        return (pc[1:0] == 2'b00) && (last_byte < {1'b0, mem_bytes});
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Program-counter generator for the fetch controller.
// Owns the pc register, the next-pc selection (redirect over stall over
// sequential step) and the legality flag for the current pc.
module fetch_pc_gen
    import mips_fetch_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_load,
    input  logic        in_run,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic [31:0] pc,
    output logic        pc_legal
);

    logic [31:0] pc_d;
    logic [31:0] pc_q;

    assign pc       = pc_q;
    assign pc_legal = pc_is_legal(pc_q, MEM_BYTES);

    // Next pc: parked at RESET_PC while loading, frozen after a fault. In RUN
    // a redirect always wins, a stall holds, and an illegal pc is left in place
    // so the fault reports the offending address.
    always_comb begin
        pc_d = pc_q;
        if (in_load) begin
            pc_d = RESET_PC;
        end else if (in_run) begin
            if (redir_valid) begin
                pc_d = redir_pc;
            end else if (stall) begin
                pc_d = pc_q;
            end else if (pc_legal) begin
                // Plain 32-bit add: wrapping past 2^32 lands on an illegal pc.
                pc_d = pc_q + PC_STEP;
            end
        end
    end

    // pc register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory loader and fetch controller.
// LOAD: bytes from the loader are written straight through to imem.
// RUN: one big-endian word is fetched per cycle at pc and delivered on
// if_valid/if_pc/if_inst one cycle later. FAULT: terminal until reset.
// Optional feature: define IMEM_FETCH_PERF_EN to build the saturating
// delivered-instruction counter on perf_fetches; otherwise it reads 0.
module imem_fetch_ctrl
    import mips_fetch_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [7:0]  ld_data,
    input  logic        ld_done,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        fault,
    output logic        ld_err,
    output logic [31:0] perf_fetches
);

    fetch_state_e state_d;
    fetch_state_e state_q;
    logic         if_valid_d;
    logic         if_valid_q;
    logic [31:0]  if_pc_d;
    logic [31:0]  if_pc_q;
    logic [31:0]  if_inst_d;
    logic [31:0]  if_inst_q;
    logic         fault_d;
    logic         fault_q;
    logic         ld_err_d;
    logic         ld_err_q;

    logic         in_load;
    logic         in_run;
    logic         ld_in_range;
    logic [31:0]  pc;
    logic         pc_legal;
    logic         fetch_slot;
    logic         fetch_go;
    logic         fetch_bad;

    assign in_load     = (state_q == LOAD);
    assign in_run      = (state_q == RUN);
    assign ld_in_range = (ld_addr < MEM_BYTES);

    // A fetch opportunity is a RUN cycle with neither redirect nor stall.
    assign fetch_slot = in_run && !redir_valid && !stall;
    assign fetch_go   = fetch_slot && pc_legal;
    assign fetch_bad  = fetch_slot && !pc_legal;

    fetch_pc_gen #(
        .MEM_BYTES (MEM_BYTES),
        .RESET_PC  (RESET_PC)
    ) u_pc_gen (
        .clk         (clk),
        .rst         (rst),
        .in_load     (in_load),
        .in_run      (in_run),
        .stall       (stall),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .pc          (pc),
        .pc_legal    (pc_legal)
    );

    // Loader handshake and write-through are combinational so a byte lands in
    // imem in the cycle it is presented; both are masked while rst is low.
    assign ld_ready  = in_load && rst;
    assign mem_we    = in_load && rst && ld_valid && ld_in_range;
    assign mem_addr  = in_load ? ld_addr : pc;
    assign mem_wdata = in_load ? ld_data : 8'h00;

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;
    assign fault    = fault_q;
    assign ld_err   = ld_err_q;

    // Next-state and next-output logic for the controller FSM.
    always_comb begin
        state_d    = state_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        fault_d    = fault_q;
        ld_err_d   = ld_err_q;
        case (state_q)
            LOAD: begin
                if (ld_valid && !ld_in_range) begin
                    ld_err_d = 1'b1;
                end
                if (ld_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (redir_valid) begin
                    // Redirect leaves a one-slot bubble; target checked later.
                    if_valid_d = 1'b0;
                end else if (fetch_go) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc;
                    if_inst_d  = mem_rdata;
                end else if (fetch_bad) begin
                    state_d    = FAULT;
                    fault_d    = 1'b1;
                    if_valid_d = 1'b0;
                end
            end
            FAULT: begin
                if_valid_d = 1'b0;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // FSM state and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= LOAD;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0;
            if_inst_q  <= 32'h0;
            fault_q    <= 1'b0;
            ld_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            fault_q    <= fault_d;
            ld_err_q   <= ld_err_d;
        end
    end

`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] perf_d;
    logic [31:0] perf_q;

    // Every accepted fetch delivers a new instruction; stalls do not re-count.
    always_comb begin
        perf_d = perf_q;
        if (fetch_go && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Saturating delivery counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_q <= 32'h0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_fetches = perf_q;
`else
    assign perf_fetches = 32'h0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl with a byte-wide imem model and a
// scoreboard of expected fetches built from the bench's own program image.
module tb_imem_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;

    logic        clk;
    logic        rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_done;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [31:0] mem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        fault;
    logic        ld_err;
    logic [31:0] perf_fetches;

    logic [7:0]  mem [0:99];
    logic [7:0]  img [0:99];
    fetch_t      sb_q [$];
    fetch_t      exp_f;
    logic [31:0] mpc;
    logic [31:0] exp_perf;
    int          n_pass;
    int          n_total;

    imem_fetch_ctrl #(
        .MEM_BYTES (100),
        .RESET_PC  (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_done      (ld_done),
        .stall        (stall),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .fault        (fault),
        .ld_err       (ld_err),
        .perf_fetches (perf_fetches)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-wide instruction memory: synchronous write, combinational big-endian read.
    always @(posedge clk) begin
        if (mem_we && (mem_addr < 32'd100)) mem[mem_addr[6:0]] <= mem_wdata;
    end

    always_comb begin
        mem_rdata = 32'h0;
        if (mem_addr < 32'd97)
            mem_rdata = {mem[mem_addr[6:0]], mem[mem_addr[6:0] + 7'd1],
                         mem[mem_addr[6:0] + 7'd2], mem[mem_addr[6:0] + 7'd3]};
    end

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        if (a > 32'd96) return 32'h0;
        return {img[a[6:0]], img[a[6:0] + 7'd1], img[a[6:0] + 7'd2], img[a[6:0] + 7'd3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Predict one delivery at the model pc and advance the model.
    task automatic push_fetch();
        sb_q.push_back('{pc: mpc, inst: exp_word(mpc)});
        mpc = mpc + 32'd4;
    endtask

    task automatic test_reset();
        rst = 1'b0; ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 8'hFF;
        #1;
        n_total++; if (ld_ready !== 1'b0) $display("FAIL rst_ld_ready: got %b want 0", ld_ready); else n_pass++;
        n_total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else n_pass++;
        tick();
        n_total++; if (if_valid !== 1'b0) $display("FAIL rst_if_valid: got %b want 0", if_valid); else n_pass++;
        n_total++; if (if_pc !== 32'h0) $display("FAIL rst_if_pc: got %h want 0", if_pc); else n_pass++;
        n_total++; if (if_inst !== 32'h0) $display("FAIL rst_if_inst: got %h want 0", if_inst); else n_pass++;
        n_total++; if (fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", fault); else n_pass++;
        n_total++; if (ld_err !== 1'b0) $display("FAIL rst_ld_err: got %b want 0", ld_err); else n_pass++;
        n_total++; if (perf_fetches !== 32'h0) $display("FAIL rst_perf: got %0d want 0", perf_fetches); else n_pass++;
        rst = 1'b1; ld_valid = 1'b0;
        #1;
        n_total++; if (ld_ready !== 1'b1) $display("FAIL load_ld_ready: got %b want 1", ld_ready); else n_pass++;
    endtask

    task automatic test_load_range();
        ld_valid = 1'b1; ld_addr = 32'd100; ld_data = 8'hAA;
        #1;
        n_total++; if (mem_we !== 1'b0) $display("FAIL range_mem_we: got %b want 0", mem_we); else n_pass++;
        tick();
        ld_valid = 1'b0;
        n_total++; if (ld_err !== 1'b1) $display("FAIL range_ld_err: got %b want 1", ld_err); else n_pass++;
        n_total++; if (ld_ready !== 1'b1) $display("FAIL range_stays_load: got %b want 1", ld_ready); else n_pass++;
    endtask

    task automatic test_load_run();
        for (int a = 0; a < 100; a++) begin
            ld_valid = 1'b1; ld_addr = a; ld_data = img[a]; ld_done = (a == 99);
            if (a == 0) begin
                #1;
                n_total++; if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 8'h34)
                    $display("FAIL load_write: got we=%b addr=%h data=%h want 1/0/34", mem_we, mem_addr, mem_wdata);
                else n_pass++;
            end
            tick();
        end
        // Loader activity in RUN must be ignored.
        ld_done = 1'b0; ld_addr = 32'd5; ld_data = 8'h00;
        #1;
        n_total++; if (ld_ready !== 1'b0) $display("FAIL run_ld_ready: got %b want 0", ld_ready); else n_pass++;
        n_total++; if (mem_we !== 1'b0) $display("FAIL run_mem_we: got %b want 0", mem_we); else n_pass++;
        n_total++; if (mem_addr !== 32'h0) $display("FAIL run_mem_addr: got %h want 0", mem_addr); else n_pass++;
        n_total++; if (if_valid !== 1'b0) $display("FAIL run_entry_valid: got %b want 0", if_valid); else n_pass++;
        mpc = 32'h0;
        push_fetch();
        tick();
        ld_valid = 1'b0;
        n_total++; if (if_valid !== 1'b1) $display("FAIL first_valid: got %b want 1", if_valid); else n_pass++;
        n_total++; if (if_inst !== 32'h3408000B) $display("FAIL first_inst: got %h want 3408000b", if_inst); else n_pass++;
        if (sb_q.size() == 0) begin n_total++; $display("FAIL first_sb: got empty queue want entry"); end
        else begin
            exp_f = sb_q.pop_front();
            n_total++; if (if_pc !== exp_f.pc) $display("FAIL first_pc: got %h want %h", if_pc, exp_f.pc); else n_pass++;
        end
    endtask

    task automatic test_stall();
        push_fetch();
        tick();
        if (sb_q.size() == 0) begin n_total++; $display("FAIL pre_stall_sb: got empty queue want entry"); end
        else begin
            exp_f = sb_q.pop_front();
            n_total++; if (if_pc !== exp_f.pc || if_inst !== exp_f.inst)
                $display("FAIL pre_stall_fetch: got %h/%h want %h/%h", if_pc, if_inst, exp_f.pc, exp_f.inst);
            else n_pass++;
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (if_valid !== 1'b1 || if_pc !== 32'd4 || mem_addr !== 32'd8)
                $display("FAIL stall_hold: got v=%b pc=%h addr=%h want 1/4/8", if_valid, if_pc, mem_addr);
            else n_pass++;
        end
        stall = 1'b0;
        push_fetch();
        tick();
        if (sb_q.size() == 0) begin n_total++; $display("FAIL resume_sb: got empty queue want entry"); end
        else begin
            exp_f = sb_q.pop_front();
            n_total++; if (if_valid !== 1'b1 || if_pc !== exp_f.pc || if_inst !== exp_f.inst)
                $display("FAIL resume_fetch: got %b/%h/%h want 1/%h/%h", if_valid, if_pc, if_inst, exp_f.pc, exp_f.inst);
            else n_pass++;
        end
    endtask

    task automatic test_redirect();
        stall = 1'b1; redir_valid = 1'b1; redir_pc = 32'd32;
        tick();
        stall = 1'b0; redir_valid = 1'b0;
        n_total++; if (if_valid !== 1'b0) $display("FAIL redir_bubble: got %b want 0", if_valid); else n_pass++;
        n_total++; if (mem_addr !== 32'd32) $display("FAIL redir_addr: got %h want 20", mem_addr); else n_pass++;
        mpc = 32'd32;
        push_fetch();
        tick();
        if (sb_q.size() == 0) begin n_total++; $display("FAIL redir_sb: got empty queue want entry"); end
        else begin
            exp_f = sb_q.pop_front();
            n_total++; if (if_valid !== 1'b1 || if_pc !== exp_f.pc || if_inst !== exp_f.inst)
                $display("FAIL redir_fetch: got %b/%h/%h want 1/%h/%h", if_valid, if_pc, if_inst, exp_f.pc, exp_f.inst);
            else n_pass++;
        end
    endtask

    task automatic test_seq_fault();
        while (mpc <= 32'd96) begin
            push_fetch();
            tick();
            if (sb_q.size() == 0) begin n_total++; $display("FAIL seq_sb: got empty queue want entry"); end
            else begin
                exp_f = sb_q.pop_front();
                n_total++; if (if_valid !== 1'b1 || if_pc !== exp_f.pc || if_inst !== exp_f.inst)
                    $display("FAIL seq_fetch: got %b/%h/%h want 1/%h/%h", if_valid, if_pc, if_inst, exp_f.pc, exp_f.inst);
                else n_pass++;
            end
        end
        tick();
        n_total++; if (fault !== 1'b1) $display("FAIL edge_fault: got %b want 1", fault); else n_pass++;
        n_total++; if (if_valid !== 1'b0) $display("FAIL edge_valid: got %b want 0", if_valid); else n_pass++;
        n_total++; if (if_pc !== 32'd96) $display("FAIL edge_frozen_pc: got %h want 60", if_pc); else n_pass++;
        ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 8'h55; redir_valid = 1'b1; redir_pc = 32'h0;
        #1;
        n_total++; if (mem_we !== 1'b0 || ld_ready !== 1'b0)
            $display("FAIL fault_loader: got we=%b rdy=%b want 0/0", mem_we, ld_ready);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (fault !== 1'b1 || if_valid !== 1'b0 || if_pc !== 32'd96)
                $display("FAIL fault_sticky: got f=%b v=%b pc=%h want 1/0/60", fault, if_valid, if_pc);
            else n_pass++;
        end
        ld_valid = 1'b0; redir_valid = 1'b0;
        rst = 1'b0;
        tick();
        n_total++; if (fault !== 1'b0 || if_valid !== 1'b0 || ld_err !== 1'b0)
            $display("FAIL fault_reset: got f=%b v=%b e=%b want 0/0/0", fault, if_valid, ld_err);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (ld_ready !== 1'b1) $display("FAIL reload_ready: got %b want 1", ld_ready); else n_pass++;
    endtask

    task automatic test_perf_reset();
        // Memory survives reset, so ld_done alone restarts execution.
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        mpc = 32'h0;
        for (int i = 0; i < 5; i++) begin
            push_fetch();
            tick();
            if (sb_q.size() == 0) begin n_total++; $display("FAIL rerun_sb: got empty queue want entry"); end
            else begin
                exp_f = sb_q.pop_front();
                n_total++; if (if_valid !== 1'b1 || if_pc !== exp_f.pc || if_inst !== exp_f.inst)
                    $display("FAIL rerun_fetch: got %b/%h/%h want 1/%h/%h", if_valid, if_pc, if_inst, exp_f.pc, exp_f.inst);
                else n_pass++;
            end
        end
`ifdef IMEM_FETCH_PERF_EN
        exp_perf = 32'd5;
`else
        exp_perf = 32'd0;
`endif
        n_total++; if (perf_fetches !== exp_perf) $display("FAIL perf_count: got %0d want %0d", perf_fetches, exp_perf); else n_pass++;
        redir_valid = 1'b1; redir_pc = 32'd2;
        tick();
        redir_valid = 1'b0;
        n_total++; if (fault !== 1'b0 || if_valid !== 1'b0)
            $display("FAIL bad_redir_accept: got f=%b v=%b want 0/0", fault, if_valid);
        else n_pass++;
        tick();
        n_total++; if (fault !== 1'b1) $display("FAIL bad_redir_fault: got %b want 1", fault); else n_pass++;
        n_total++; if (perf_fetches !== exp_perf) $display("FAIL perf_after_fault: got %0d want %0d", perf_fetches, exp_perf); else n_pass++;
        rst = 1'b0;
        tick();
        n_total++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0)
            $display("FAIL run_reset_if: got %b/%h/%h want 0/0/0", if_valid, if_pc, if_inst);
        else n_pass++;
        n_total++; if (fault !== 1'b0 || ld_err !== 1'b0 || perf_fetches !== 32'h0 || ld_ready !== 1'b0)
            $display("FAIL run_reset_ctl: got f=%b e=%b p=%0d r=%b want 0/0/0/0", fault, ld_err, perf_fetches, ld_ready);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (ld_ready !== 1'b1) $display("FAIL run_reset_load: got %b want 1", ld_ready); else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0; mpc = 32'h0; exp_perf = 32'h0;
        rst = 1'b0; ld_valid = 1'b0; ld_addr = 32'h0; ld_data = 8'h0; ld_done = 1'b0;
        stall = 1'b0; redir_valid = 1'b0; redir_pc = 32'h0;
        for (int i = 0; i < 100; i++) begin
            mem[i] = 8'h0;
            img[i] = 8'($urandom_range(0, 255));
        end
        img[0] = 8'h34; img[1] = 8'h08; img[2] = 8'h00; img[3] = 8'h0B;
        test_reset();
        test_load_range();
        test_load_run();
        test_stall();
        test_redirect();
        test_seq_fault();
        test_perf_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
